// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic matmul engine.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam int N_MAX = 16;

  function automatic int acc_width(input int dw, input int k_max);
    return 2 * dw + $clog2(k_max) + 1;
  endfunction

  function automatic int klen_width(input int k_max);
    return $clog2(k_max) + 1;
  endfunction

  // One counter serves both the beat count (k_len) and the 2N-1 flush count.
  function automatic int cnt_width(input int n, input int k_max);
    int kw;
    int fw;
    kw = $clog2(k_max) + 1;
    fw = $clog2(2 * n);
    return (kw > fw) ? kw : fw;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Output-stationary MAC cell: registers a/b (forwarded right/down) and accumulates their product.
module sa_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  // The forwarding registers double as the multiplier operand registers.
  assign prod = $signed(a_out) * $signed(b_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/sa_matmul_engine.sv
// NxN output-stationary systolic matmul: C = A(NxK) x B(KxN), K set per job.
// Owns operand skewing, start/busy/done sequencing and holds results until the next start.
module sa_matmul_engine import sa_pkg::*; #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int K_MAX = 256,
  parameter int ACC_W = acc_width(DW, K_MAX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX):0]       k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DW-1:0]              a_col,
  input  logic [N*DW-1:0]              b_row,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*ACC_W-1:0]         c_flat
);

  localparam int KW = klen_width(K_MAX);
  localparam int CW = cnt_width(N, K_MAX);
  localparam logic [CW-1:0] FLUSH_LEN = CW'(2 * N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          clr;
  logic          accept;

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == LOAD) || (state_q == FLUSH);
  assign done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr = 1'b1;
          if (k_len != '0) begin
            state_d = LOAD;
            cnt_d   = CW'(k_len);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == CW'(1)) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LEN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row i of A and column j of B are delayed i/j cycles so operands meet on the diagonal wavefront.
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_z, b_z;
    assign a_z = accept ? a_col[i*DW +: DW] : '0;
    assign b_z = accept ? b_row[i*DW +: DW] : '0;
    if (i == 0) begin : g_d0
      assign a_edge[i] = a_z;
      assign b_edge[i] = b_z;
    end else begin : g_dn
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_z;
          b_sr[0] <= b_z;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  logic [DW-1:0] a_h [N][N];
  logic [DW-1:0] b_v [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      sa_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .a_in  ((j == 0) ? a_edge[i] : a_h[i][j-1]),
        .b_in  ((i == 0) ? b_edge[j] : b_v[i-1][j]),
        .a_out (a_h[i][j]),
        .b_out (b_v[i][j]),
        .acc   (c_flat[(i*N+j)*ACC_W +: ACC_W])
      );
    end
  end

  // Beyond K_MAX the accumulator width no longer guarantees freedom from wrap.
  assert property (@(posedge clk) disable iff (rst)
    (start && (state_q == IDLE || state_q == DONE)) |-> (k_len <= KW'(K_MAX)));

endmodule

// File: tb/tb_sa_matmul_engine.sv
// Randomised bench for sa_matmul_engine against a plain triple-loop matrix product.
module tb_sa_matmul_engine;
  import sa_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 256;
  localparam int ACC_W = acc_width(DW, K_MAX);
  localparam int KW    = $clog2(K_MAX) + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [KW-1:0]          k_len = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N*DW-1:0]        a_col = '0;
  logic [N*DW-1:0]        b_row = '0;
  logic                   busy;
  logic                   done;
  logic [N*N*ACC_W-1:0]   c_flat;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int ma [N][K_MAX];
  int mb [K_MAX][N];

  sa_matmul_engine #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .busy     (busy),
    .done     (done),
    .c_flat   (c_flat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint cval(input int i, input int j);
    logic signed [ACC_W-1:0] v;
    v = c_flat[(i*N+j)*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        ma[i][k] = 0;
        mb[k][i] = 0;
      end
  endtask

  task automatic drive_beat(input int idx);
    for (int r = 0; r < N; r++) begin
      a_col[r*DW +: DW] = DW'(ma[r][idx]);
      b_row[r*DW +: DW] = DW'(mb[idx][r]);
    end
  endtask

  // Called at a negedge with the engine in IDLE or DONE.
  task automatic run_job(input string nm, input int k, input int bubble, input bit flush_start);
    longint exp_c [N][N];
    int idx, e0, dcyc, busy_low, ready_hi, guard;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int kk = 0; kk < k; kk++)
          exp_c[i][j] += longint'(ma[i][kk]) * longint'(mb[kk][j]);
      end

    // in_valid high alongside start: that beat must not be taken.
    start = 1'b1; k_len = KW'(k); in_valid = 1'b1; a_col = $urandom; b_row = $urandom;
    @(negedge clk);
    start = 1'b0;
    idx = 0; guard = 0; busy_low = 0; ready_hi = 0; e0 = cyc;
    while (idx < k && guard < 4000) begin
      if (!busy) busy_low++;
      in_valid = ($urandom_range(99) >= bubble);
      if (in_valid) drive_beat(idx);
      else begin a_col = $urandom; b_row = $urandom; end
      if (in_valid && in_ready) begin idx++; e0 = cyc + 1; end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0; a_col = $urandom; b_row = $urandom;
    chk({nm, "_beats"}, idx, k);

    dcyc = -1;
    for (int t = 0; t < 100; t++) begin
      if (done) begin dcyc = cyc; break; end
      if (!busy) busy_low++;
      if (in_ready) ready_hi++;
      start = flush_start && (t == 0);
      k_len = KW'(3);
      @(negedge clk);
      start = 1'b0;
    end
    chk({nm, "_done_lat"}, dcyc, e0 + 2*N - 1);
    chk({nm, "_busy_gap"}, busy_low, 0);
    chk({nm, "_ready_flush"}, ready_hi, 0);
    chk({nm, "_busy_done"}, busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", nm, i, j), cval(i, j), exp_c[i][j]);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_hold"}, cval(N-1, N-1), exp_c[N-1][N-1]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mats();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cflat", |c_flat, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 example embedded in the top-left corner
    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_job("t2x2", 2, 0, 1'b0);
    chk("t2x2_c00_const", cval(0, 0), 19);
    chk("t2x2_c11_const", cval(1, 1), 50);

    // identity x B
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = (i == k) ? 1 : 0;
        mb[i][k] = i * N + k;
      end
    run_job("ident", 4, 0, 1'b0);

    // random operands with bubbles
    for (int r = 0; r < 3; r++) begin
      clear_mats();
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 8; k++) begin
          ma[i][k] = int'($urandom_range(255)) - 128;
          mb[k][i] = int'($urandom_range(255)) - 128;
        end
      run_job($sformatf("rnd%0d", r), 8, 30, 1'b0);
    end

    // extremes at K_MAX
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        ma[i][k] = -128;
        mb[k][i] = -128;
      end
    run_job("ext_nn", K_MAX, 0, 1'b0);
    chk("ext_nn_const", cval(2, 3), 4194304);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++)
        mb[k][i] = 127;
    run_job("ext_np", K_MAX, 0, 1'b0);
    chk("ext_np_const", cval(1, 0), -4161536);

    // k_len = 0: immediate done, zero result, no operand acceptance
    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("k0_done", done, 1);
    chk("k0_cflat", |c_flat, 0);
    chk("k0_ready", in_ready, 0);
    chk("k0_busy", busy, 0);
    @(negedge clk);
    chk("k0_done_pulse", done, 0);
    chk("k0_ready2", in_ready, 0);

    // abort a job with reset after 3 beats
    start = 1'b1; k_len = KW'(8);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      a_col = $urandom | 32'h0101_0101;
      b_row = $urandom | 32'h0101_0101;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cflat", |c_flat, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        ma[i][k] = int'($urandom_range(255)) - 128;
        mb[k][i] = int'($urandom_range(255)) - 128;
      end
    run_job("fresh", 2, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
